// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, the NOP word and the fetch-state enum.
package pipeline_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [31:0] NOP_WORD = 32'h0;

  typedef enum logic {
    RUN,
    HALT
  } fetch_state_t;
endpackage

// File: rtl/if_pc_sel.sv
// Next-PC mux for the fetch stage: hold, sequential +4, or branch target.
module if_pc_sel
  import pipeline_pkg::*;
(
  input  logic        i_hold,
  input  logic        i_redirect,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_br,
  input  logic [31:0] i_imm,
  output logic [31:0] o_next_pc
);
  logic [31:0] w_seq;
  logic [31:0] w_target;

  assign w_seq = i_pc + 32'd4;
  // Branch offsets are relative to the branch's own fall-through address.
  assign w_target = i_pc_br + 32'd4 + (i_imm << 2);

  always_comb begin
    o_next_pc = w_seq;
    if (i_hold)
      o_next_pc = i_pc;
    else if (i_redirect)
      o_next_pc = w_target;
  end
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, IF/ID register, branch redirect, HALT.
// Optional fetch/flush counters are built when IF_STAGE_STATS_EN is defined.
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               beq_taken,
  input  logic [31:0]        beq_imm,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instruction,
  output logic [31:0]        pc_out,
  output logic               valid,
  output logic               halted,
  output logic [31:0]        fetch_count,
  output logic [31:0]        flush_count
);
  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc_out;
  logic         r_valid;
  logic [31:0]  w_next_pc;
  logic         w_hold;
  logic         w_fetch;
  logic         w_flush;

  assign w_hold  = (r_state == HALT) | stall;
  assign w_fetch = ~w_hold & ~beq_taken;
  assign w_flush = ~w_hold & beq_taken;

  if_pc_sel u_pc_sel (
    .i_hold     (w_hold),
    .i_redirect (beq_taken),
    .i_pc       (r_pc),
    .i_pc_br    (r_pc_out),
    .i_imm      (beq_imm),
    .o_next_pc  (w_next_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= RUN;
      r_pc     <= RESET_PC;
      r_instr  <= NOP_WORD;
      r_pc_out <= 32'h0;
      r_valid  <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      if (r_state == HALT) begin
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
      end else if (w_flush) begin
        r_instr  <= NOP_WORD;
        r_valid  <= 1'b0;
        r_pc_out <= r_pc;
      end else if (w_fetch) begin
        r_instr  <= imem_rdata;
        r_valid  <= 1'b1;
        r_pc_out <= r_pc;
        if (imem_rdata[31:26] == OP_HALT)
          r_state <= HALT;
      end
    end
  end

`ifdef IF_STAGE_STATS_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_cnt <= 32'h0;
      r_flush_cnt <= 32'h0;
    end else begin
      if (w_fetch)
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_flush)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign fetch_count = r_fetch_cnt;
  assign flush_count = r_flush_cnt;
`else
  assign fetch_count = 32'h0;
  assign flush_count = 32'h0;
`endif

  assign imem_addr   = r_pc[IMEM_AW+1:2];
  assign instruction = r_instr;
  assign pc_out      = r_pc_out;
  assign valid       = r_valid;
  assign halted      = (r_state == HALT);
endmodule

// File: tb/tb_if_stage.sv
// Directed plus randomized bench for if_stage against a behavioural fetch model.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        beq_taken = 1'b0;
  logic [31:0] beq_imm = 32'h0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        valid;
  logic        halted;
  logic [31:0] fetch_count;
  logic [31:0] flush_count;

  logic [7:0]  a2;
  logic [31:0] rd2;
  logic [31:0] ins2;
  logic [31:0] pco2;
  logic        val2;
  logic        hlt2;
  logic [31:0] fc2;
  logic [31:0] flc2;

  logic [31:0] mem [256];

  int total = 0;
  int bad = 0;

  // Behavioural model of the architected fetch state.
  logic [31:0] m_pc;
  logic [31:0] m_ins;
  logic [31:0] m_pco;
  logic        m_val;
  logic        m_hlt;
  logic [31:0] m_fc;
  logic [31:0] m_flc;

  assign imem_rdata = mem[imem_addr];
  assign rd2 = mem[a2];

  always #5 clk = ~clk;

  if_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .beq_taken   (beq_taken),
    .beq_imm     (beq_imm),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc_out      (pc_out),
    .valid       (valid),
    .halted      (halted),
    .fetch_count (fetch_count),
    .flush_count (flush_count)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .stall       (1'b0),
    .beq_taken   (1'b0),
    .beq_imm     (32'h0),
    .imem_addr   (a2),
    .imem_rdata  (rd2),
    .instruction (ins2),
    .pc_out      (pco2),
    .valid       (val2),
    .halted      (hlt2),
    .fetch_count (fc2),
    .flush_count (flc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_fc;
    logic [31:0] e_flc;
`ifdef IF_STAGE_STATS_EN
    e_fc  = m_fc;
    e_flc = m_flc;
`else
    e_fc  = 32'h0;
    e_flc = 32'h0;
`endif
    chk("imem_addr", {24'h0, imem_addr}, {24'h0, m_pc[9:2]});
    chk("instruction", instruction, m_ins);
    chk("pc_out", pc_out, m_pco);
    chk("valid", {31'h0, valid}, {31'h0, m_val});
    chk("halted", {31'h0, halted}, {31'h0, m_hlt});
    chk("fetch_count", fetch_count, e_fc);
    chk("flush_count", flush_count, e_flc);
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_ins = 32'h0;
    m_pco = 32'h0;
    m_val = 1'b0;
    m_hlt = 1'b0;
    m_fc  = 32'h0;
    m_flc = 32'h0;
  endtask

  task automatic model_edge(input logic st, input logic bt,
                            input logic [31:0] imm);
    logic [31:0] w;
    logic [31:0] br_pc;
    if (m_hlt) begin
      m_ins = 32'h0;
      m_val = 1'b0;
    end else if (st) begin
      m_ins = m_ins;
    end else if (bt) begin
      br_pc = m_pco;
      m_pco = m_pc;
      m_pc  = br_pc + 4 + imm * 4;
      m_ins = 32'h0;
      m_val = 1'b0;
      m_flc = m_flc + 1;
    end else begin
      w     = mem[m_pc[9:2]];
      m_ins = w;
      m_pco = m_pc;
      m_val = 1'b1;
      m_pc  = m_pc + 4;
      m_fc  = m_fc + 1;
      if (w[31:26] == 6'b111111)
        m_hlt = 1'b1;
    end
  endtask

  task automatic cyc(input logic st, input logic bt, input logic [31:0] imm);
    stall     = st;
    beq_taken = bt;
    beq_imm   = imm;
    @(posedge clk);
    model_edge(st, bt, imm);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    stall = 1'b0;
    beq_taken = 1'b0;
    check_all();
  endtask

  initial begin
    logic [31:0] imm;
    logic        st;
    logic        bt;
    for (int i = 0; i < 256; i++)
      mem[i] = 32'h0000_0020 + (i << 16);
    mem[0] = 32'h8C01_0004;
    mem[1] = 32'h0000_0020;
    mem[2] = 32'h0000_0020;
    mem[3] = 32'h0000_0020;
    mem[255] = 32'h0000_0020;
    model_reset();
    @(posedge clk);
    do_reset();
    chk("wrap_reset_addr", {24'h0, a2}, 32'h0000_00FF);

    cyc(0, 0, 0);
    chk("lw_first", instruction, 32'h8C01_0004);
    chk("wrap_pc_out", pco2, 32'hFFFF_FFFC);
    chk("wrap_addr", {24'h0, a2}, 32'h0);
    chk("wrap_instr", ins2, 32'h0000_0020);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("br_slot_pc", pc_out, 32'h8);
    cyc(0, 1, 3);
    chk("bubble_valid", {31'h0, valid}, 32'h0);
    cyc(0, 0, 0);
    chk("br_target_pc", pc_out, 32'h18);
    chk("br_target_ins", instruction, 32'h0006_0020);

    for (int k = 0; k < 3; k++)
      cyc(1, 1, 2);
    chk("stall_pc", pc_out, 32'h18);
    cyc(0, 1, 2);
    cyc(0, 0, 0);
    chk("stall_redirect", pc_out, 32'h24);
    cyc(0, 0, 0);

    mem[2] = 32'hFC00_0000;
    do_reset();
    for (int k = 0; k < 3; k++)
      cyc(0, 0, 0);
    chk("halt_entry", {31'h0, halted}, 32'h1);
    cyc(0, 0, 0);
    cyc(1, 1, 5);
    cyc(0, 1, 5);
    chk("halt_pc_stuck", pc_out, 32'h8);
    chk("halt_invalid", {31'h0, valid}, 32'h0);
    do_reset();
    cyc(0, 0, 0);
    chk("refetch_pc", pc_out, 32'h0);

    mem[2] = 32'h0000_0020;
    mem[3] = 32'hFC00_0000;
    do_reset();
    for (int k = 0; k < 3; k++)
      cyc(0, 0, 0);
    cyc(0, 1, 3);
    cyc(0, 0, 0);
    chk("squash_halt", {31'h0, halted}, 32'h0);
    chk("squash_target", pc_out, 32'h18);

    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 19) == 0) ? (32'hFC00_0000 | $urandom_range(0, 255))
                                            : ($urandom & 32'h03FF_FFFF);
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        st  = ($urandom_range(0, 4) == 0);
        bt  = ($urandom_range(0, 4) == 0);
        imm = $urandom_range(0, 31) - 16;
        cyc(st, bt, imm);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
